// File: rtl/clock_enable_chain.sv
// clock_enable_chain: STAGES cascaded one-cycle clock-enable pulses from CLK_IN.
// Each stage divides the tick of the stage below it. A divisor written at
// runtime is held in a shadow register and takes effect at the stage's next
// wrap. HOLD_I freezes the chain; SYNC_CLR_I restarts every phase.
// Optional feature macro: CLKGEN_SQUARE_OUT_EN (per-stage 50% square outputs).
module clock_enable_chain #(
   parameter int unsigned                   STAGES    = 5,
   parameter int unsigned                   CNT_WIDTH = 12,
   parameter logic [STAGES*CNT_WIDTH-1:0]   DIV_INIT  = {12'd1000, 12'd50, 12'd100, 12'd10, 12'd2},
   parameter int unsigned                   SEL_WIDTH = 3
) (
   input  logic                 CLK_IN,
   input  logic                 RESET_N,
   input  logic                 HOLD_I,
   input  logic                 SYNC_CLR_I,
   input  logic                 DIV_WR_I,
   input  logic [SEL_WIDTH-1:0] DIV_SEL_I,
   input  logic [CNT_WIDTH-1:0] DIV_VAL_I,
   output logic [STAGES-1:0]    DIV_PEND_O,
   output logic [STAGES-1:0]    CLK_EN_O,
   output logic [STAGES-1:0]    CLK_SQ_O
);

   logic [CNT_WIDTH-1:0] r_cnt    [STAGES];
   logic [CNT_WIDTH-1:0] r_active [STAGES];
   logic [CNT_WIDTH-1:0] r_shadow [STAGES];
   logic [STAGES-1:0]    r_pend;
   logic [STAGES-1:0]    r_en;

   logic [STAGES-1:0]    w_in_en;
   logic [STAGES-1:0]    w_tick;
   logic [STAGES-1:0]    w_wr_hit;

   // Ripple the terminal ticks up the chain; divisor 0 behaves like 1.
   always_comb begin
      logic                 v_in_en;
      logic [CNT_WIDTH-1:0] v_term;
      w_in_en  = '0;
      w_tick   = '0;
      w_wr_hit = '0;
      v_in_en  = 1'b1;
      v_term   = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         v_term      = (r_active[k] == '0) ? '0 : r_active[k] - CNT_WIDTH'(1);
         w_in_en[k]  = v_in_en;
         w_tick[k]   = v_in_en && (r_cnt[k] == v_term) && !HOLD_I && !SYNC_CLR_I;
         w_wr_hit[k] = DIV_WR_I && (DIV_SEL_I == SEL_WIDTH'(k));
         v_in_en     = w_tick[k];
      end
   end

   // Stage counters, divisor shadow/apply and registered enable pulses.
   always_ff @(posedge CLK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pend <= '0;
         r_en   <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_cnt[k]    <= '0;
            r_active[k] <= DIV_INIT[k*CNT_WIDTH +: CNT_WIDTH];
            r_shadow[k] <= DIV_INIT[k*CNT_WIDTH +: CNT_WIDTH];
         end
      end else if (SYNC_CLR_I) begin
         r_pend <= '0;
         r_en   <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_cnt[k] <= '0;
            if (w_wr_hit[k]) begin
               r_active[k] <= DIV_VAL_I;
               r_shadow[k] <= DIV_VAL_I;
            end else if (r_pend[k]) begin
               r_active[k] <= r_shadow[k];
            end
         end
      end else begin
         r_en <= w_tick;
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (w_tick[k]) begin
               r_cnt[k] <= '0;
            end else if (w_in_en[k] && !HOLD_I) begin
               r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
            end
            // The wrap consumes the shadow held before this cycle; a write
            // landing on the same edge re-arms pending for the next wrap.
            if (w_tick[k] && r_pend[k]) begin
               r_active[k] <= r_shadow[k];
               r_pend[k]   <= 1'b0;
            end
            if (w_wr_hit[k]) begin
               r_shadow[k] <= DIV_VAL_I;
               r_pend[k]   <= 1'b1;
            end
         end
      end
   end

   assign DIV_PEND_O = r_pend;
   assign CLK_EN_O   = r_en;

`ifdef CLKGEN_SQUARE_OUT_EN
   logic [STAGES-1:0] r_sq;

   // Square wave toggles on every stage tick; frozen during hold.
   always_ff @(posedge CLK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sq <= '0;
      end else if (SYNC_CLR_I) begin
         r_sq <= '0;
      end else begin
         r_sq <= r_sq ^ w_tick;
      end
   end

   assign CLK_SQ_O = r_sq;
`else
   assign CLK_SQ_O = '0;
`endif

endmodule
